lcd_screen_ctrl: RTL and testbench

Screen-buffer controller and write scheduler for the 2x16 character LCD. It runs the power-up command sequence, then keeps a 32-character shadow buffer that two requesters (for example game status and score) update one character at a time. Whenever the buffer has changed, it streams a full screen refresh as command/data bytes to the downstream LCD byte writer. It sits between the game logic and the LCD nibble driver, and is the only block that talks to that driver.

---
 rtl/lcd_screen_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_lcd_screen_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_screen_ctrl.sv
// lcd_screen_ctrl: screen-buffer controller and write scheduler for a 2x16 character LCD.
//
// Sends the LCD power-up command sequence, then waits CLEAR_WAIT cycles for the clear to
// complete. After that it keeps a 32-character shadow buffer that two requesters update one
// character per cycle, with round-robin arbitration on collisions. Whenever the buffer is
// dirty it streams a full refresh to the LCD byte writer: 0x80, line 1, 0xC0, line 2.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   reqN_wr/addr/char, reqN_ack   requester N write port; ack is combinational (grant & wr)
//   out_valid/out_rs/out_byte     byte offered to the LCD writer (rs: 0 command, 1 data)
//   out_ready                     writer takes the byte on an edge where out_valid is high
//   busy                          init or refresh in progress
//   init_done                     power-up sequence complete (sticky until reset)
module lcd_screen_ctrl #(
    parameter int unsigned CLEAR_WAIT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_wr,
    input  logic [4:0] req0_addr,
    input  logic [7:0] req0_char,
    output logic       req0_ack,
    input  logic       req1_wr,
    input  logic [4:0] req1_addr,
    input  logic [7:0] req1_char,
    output logic       req1_ack,
    output logic       out_valid,
    output logic       out_rs,
    output logic [7:0] out_byte,
    input  logic       out_ready,
    output logic       busy,
    output logic       init_done
);

    localparam int unsigned CntW = $clog2(CLEAR_WAIT + 1);

    typedef enum logic [2:0] {
        StInit,
        StClrw,
        StIdle,
        StLine1,
        StLine2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        init_step_q, init_step_d;
    logic [4:0]        idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              dirty_q, dirty_d;
    logic              rr_q, rr_d;      // 1: requester 1 wins the next collision
    logic [7:0]        buf_q [32];
    logic [7:0]        buf_d [32];
    logic              out_valid_q, out_valid_d;
    logic              out_rs_q, out_rs_d;
    logic [7:0]        out_byte_q, out_byte_d;
    logic              busy_q, busy_d;
    logic              init_done_q, init_done_d;

    logic grant0, grant1, wr_any, xfer;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    init_cmd = 8'h28;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    // Gating with rst keeps acks low while reset is held.
    assign grant0 = rst & req0_wr & (~req1_wr | ~rr_q);
    assign grant1 = rst & req1_wr & (~req0_wr | rr_q);
    assign wr_any = grant0 | grant1;
    assign xfer   = out_valid_q & out_ready;

    assign req0_ack  = grant0;
    assign req1_ack  = grant1;
    assign out_valid = out_valid_q;
    assign out_rs    = out_rs_q;
    assign out_byte  = out_byte_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;

    // Buffer write port and round-robin pointer (only a collision moves the pointer).
    always_comb begin
        buf_d = buf_q;
        if (grant0) begin
            buf_d[req0_addr] = req0_char;
        end else if (grant1) begin
            buf_d[req1_addr] = req1_char;
        end
        rr_d = (req0_wr & req1_wr) ? grant0 : rr_q;
    end

    always_comb begin
        state_d     = state_q;
        init_step_d = init_step_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_rs_d    = out_rs_q;
        out_byte_d  = out_byte_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        // A write in the same cycle always wins over a clear, so nothing is lost.
        dirty_d     = dirty_q | wr_any;

        unique case (state_q)
            StInit: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_rs_d    = 1'b0;
                    out_byte_d  = init_cmd(init_step_q);
                end else if (out_ready) begin
                    if (init_step_q == 2'd3) begin
                        out_valid_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = StClrw;
                    end else begin
                        init_step_d = init_step_q + 2'd1;
                        out_byte_d  = init_cmd(init_step_q + 2'd1);
                    end
                end
            end
            StClrw: begin
                if (cnt_q == CntW'(CLEAR_WAIT - 1)) begin
                    init_done_d = 1'b1;
                    busy_d      = dirty_d;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (dirty_q) begin
                    dirty_d     = wr_any;
                    out_valid_d = 1'b1;
                    out_rs_d    = 1'b0;
                    out_byte_d  = 8'h80;
                    idx_d       = 5'd0;
                    busy_d      = 1'b1;
                    state_d     = StLine1;
                end
            end
            StLine1: begin
                // out_rs_q low means the line-address command is the byte just taken.
                if (xfer) begin
                    if (!out_rs_q) begin
                        out_rs_d   = 1'b1;
                        out_byte_d = buf_q[idx_q];
                    end else if (idx_q == 5'd15) begin
                        out_rs_d   = 1'b0;
                        out_byte_d = 8'hC0;
                        idx_d      = 5'd16;
                        state_d    = StLine2;
                    end else begin
                        idx_d      = idx_q + 5'd1;
                        out_byte_d = buf_q[idx_q + 5'd1];
                    end
                end
            end
            StLine2: begin
                if (xfer) begin
                    if (!out_rs_q) begin
                        out_rs_d   = 1'b1;
                        out_byte_d = buf_q[idx_q];
                    end else if (idx_q == 5'd31) begin
                        out_valid_d = 1'b0;
                        out_rs_d    = 1'b0;
                        idx_d       = 5'd0;
                        busy_d      = dirty_d;
                        state_d     = StIdle;
                    end else begin
                        idx_d      = idx_q + 5'd1;
                        out_byte_d = buf_q[idx_q + 5'd1];
                    end
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StInit;
            init_step_q <= 2'd0;
            idx_q       <= 5'd0;
            cnt_q       <= '0;
            dirty_q     <= 1'b1;
            rr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_rs_q    <= 1'b0;
            out_byte_q  <= 8'h00;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                buf_q[i] <= 8'h20;
            end
        end else begin
            state_q     <= state_d;
            init_step_q <= init_step_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            dirty_q     <= dirty_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_rs_q    <= out_rs_d;
            out_byte_q  <= out_byte_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            for (int i = 0; i < 32; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_lcd_screen_ctrl.sv
// Self-checking bench for lcd_screen_ctrl: directed scenarios plus randomized writes and
// randomized backpressure, checked against a character-array model of the screen.
module tb_lcd_screen_ctrl;

    localparam int unsigned CW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_wr = 1'b0, req1_wr = 1'b0;
    logic [4:0] req0_addr = '0, req1_addr = '0;
    logic [7:0] req0_char = '0, req1_char = '0;
    logic       req0_ack, req1_ack;
    logic       out_valid, out_rs, out_ready = 1'b1;
    logic [7:0] out_byte;
    logic       busy, init_done;

    lcd_screen_ctrl #(.CLEAR_WAIT(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_char(req0_char), .req0_ack(req0_ack),
        .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_char(req1_char), .req1_ack(req1_ack),
        .out_valid(out_valid), .out_rs(out_rs), .out_byte(out_byte), .out_ready(out_ready),
        .busy(busy), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rs;
        logic [7:0] b;
    } xfer_t;

    int    cyc = 0;
    xfer_t mon_q[$];
    int    mon_cyc[$];
    xfer_t got[$];
    int    got_cyc[$];

    logic [7:0] mbuf [32];
    bit         mrr;           // model: requester 1 wins the next collision
    xfer_t      exp_pass [34];
    xfer_t      exp1 [34];
    int         checks = 0;
    int         failures = 0;
    bit         ready_rand = 1'b0;
    logic [7:0] cmds [4] = '{8'h28, 8'h0C, 8'h06, 8'h01};

    always @(posedge clk) cyc <= cyc + 1;

    // Every byte the writer takes, recorded mid-cycle before the edge that completes it.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            mon_q.push_back({out_rs, out_byte});
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        mrr = 1'b0;
    endfunction

    // Expected refresh: line-1 address, 16 chars, line-2 address, 16 chars.
    function automatic void build_pass();
        exp_pass[0]  = {1'b0, 8'h80};
        exp_pass[17] = {1'b0, 8'hC0};
        for (int i = 0; i < 16; i++) begin
            exp_pass[1 + i]  = {1'b1, mbuf[i]};
            exp_pass[18 + i] = {1'b1, mbuf[16 + i]};
        end
    endfunction

    // One write cycle: drive, sample acks mid-cycle, apply the arbitration rule to the model.
    task automatic write_cycle(input bit w0, input logic [4:0] a0, input logic [7:0] c0,
                               input bit w1, input logic [4:0] a1, input logic [7:0] c1,
                               output logic k0, output logic k1, output bit g0, output bit g1);
        @(posedge clk);
        #1;
        req0_wr = w0; req0_addr = a0; req0_char = c0;
        req1_wr = w1; req1_addr = a1; req1_char = c1;
        @(negedge clk);
        k0 = req0_ack;
        k1 = req1_ack;
        g0 = w0 && (!w1 || !mrr);
        g1 = w1 && !g0;
        if (w0 && w1) mrr = g0;
        if (g0) mbuf[a0] = c0;
        else if (g1) mbuf[a1] = c1;
    endtask

    task automatic release_reqs();
        @(posedge clk);
        #1;
        req0_wr = 1'b0;
        req1_wr = 1'b0;
    endtask

    // Gather all transfers until the block has been idle for three cycles.
    task automatic collect(input int budget, output bit ok);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            @(posedge clk);
            #2;
            if (!busy && !out_valid) quiet++;
            else quiet = 0;
            n++;
        end
        ok = (quiet >= 3);
        got = mon_q;
        got_cyc = mon_cyc;
        mon_q.delete();
        mon_cyc.delete();
    endtask

    task automatic wait_xfers(input int n, output bit ok);
        int t = 0;
        while (mon_q.size() < n && t < 200) begin
            @(posedge clk);
            #2;
            t++;
        end
        ok = (mon_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0_wr = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out_rs !== 1'b0) begin failures++; $display("FAIL reset_rs got=%b want=0", out_rs); end
        checks++; if (out_byte !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h want=00", out_byte); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b want=1", busy); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b want=0", init_done); end
        checks++; if (req0_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", req0_ack); end
        req0_wr = 1'b0;
    endtask

    task automatic test_powerup();
        bit ok;
        int gap;
        model_reset();
        mon_q.delete(); mon_cyc.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_byte !== 8'h28) begin
            failures++; $display("FAIL first_byte got=%b/%h want=1/28", out_valid, out_byte); end
        collect(400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL powerup_quiet got=busy want=idle"); end
        checks++; if (got.size() != 38) begin failures++; $display("FAIL powerup_len got=%0d want=38", got.size()); end
        if (got.size() == 38) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got[i] !== {1'b0, cmds[i]}) begin
                    failures++; $display("FAIL init_cmd%0d got=%h want=%h", i, got[i], {1'b0, cmds[i]}); end
            end
            checks++; if (got_cyc[3] - got_cyc[0] != 3) begin
                failures++; $display("FAIL init_span got=%0d want=3", got_cyc[3] - got_cyc[0]); end
            gap = got_cyc[4] - got_cyc[3] - 1;
            checks++; if (gap < CW || gap > CW + 1) begin
                failures++; $display("FAIL clear_wait got=%0d want=%0d..%0d", gap, CW, CW + 1); end
            build_pass();
            for (int i = 0; i < 34; i++) begin
                checks++; if (got[4 + i] !== exp_pass[i]) begin
                    failures++; $display("FAIL powerup_pass[%0d] got=%h want=%h", i, got[4 + i], exp_pass[i]); end
            end
            checks++; if (got_cyc[37] - got_cyc[4] != 33) begin
                failures++; $display("FAIL refresh_span got=%0d want=33", got_cyc[37] - got_cyc[4]); end
        end
        checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done got=%b want=1", init_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic collision(input logic [7:0] c0, input logic [4:0] a0,
                             input logic [7:0] c1, input logic [4:0] a1, input string nm);
        logic k0, k1;
        bit g0, g1, ok;
        write_cycle(1'b1, a0, c0, 1'b1, a1, c1, k0, k1, g0, g1);
        checks++; if (k0 !== g0 || k1 !== g1) begin
            failures++; $display("FAIL %s_first got=%b%b want=%b%b", nm, k0, k1, g0, g1); end
        write_cycle(!g0, a0, c0, !g1, a1, c1, k0, k1, g0, g1);
        checks++; if (k0 !== g0 || k1 !== g1) begin
            failures++; $display("FAIL %s_second got=%b%b want=%b%b", nm, k0, k1, g0, g1); end
        release_reqs();
        collect(500, ok);
        build_pass();
        checks++; if (!ok || got.size() == 0 || got.size() % 34 != 0) begin
            failures++; $display("FAIL %s_len got=%0d want=multiple of 34", nm, got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== exp_pass[i % 34]) begin
                failures++; $display("FAIL %s_pass[%0d] got=%h want=%h", nm, i, got[i], exp_pass[i % 34]); end
        end
    endtask

    task automatic test_arbitration();
        collision(8'h41, 5'd0, 8'h42, 5'd31, "collide1");
        checks++; if (got.size() < 34 || got[1] !== {1'b1, 8'h41} || got[33] !== {1'b1, 8'h42}) begin
            failures++; $display("FAIL collide1_ends got=%0d bytes want=41 first 42 last", got.size()); end
        // mrr now says requester 1 wins; the DUT ack must follow.
        collision(8'h43, 5'd1, 8'h44, 5'd30, "collide2");
    endtask

    task automatic test_backpressure();
        logic k0, k1;
        bit g0, g1, ok;
        write_cycle(1'b1, 5'd5, 8'h3F, 1'b0, 5'd0, 8'h00, k0, k1, g0, g1);
        checks++; if (k0 !== 1'b1) begin failures++; $display("FAIL bp_ack got=%b want=1", k0); end
        release_reqs();
        wait_xfers(8, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_reach got=%0d want=8", mon_q.size()); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_rs !== 1'b1 || out_byte !== mbuf[7]) begin
                failures++; $display("FAIL bp_hold%0d got=%b/%b/%h want=1/1/%h", i, out_valid, out_rs, out_byte, mbuf[7]); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        collect(500, ok);
        build_pass();
        checks++; if (!ok || got.size() != 34) begin failures++; $display("FAIL bp_len got=%0d want=34", got.size()); end
        for (int i = 0; i < got.size() && i < 34; i++) begin
            checks++; if (got[i] !== exp_pass[i]) begin
                failures++; $display("FAIL bp_pass[%0d] got=%h want=%h", i, got[i], exp_pass[i]); end
        end
    endtask

    task automatic test_mid_write();
        logic k0, k1;
        bit g0, g1, ok;
        write_cycle(1'b1, 5'd10, 8'h2A, 1'b0, 5'd0, 8'h00, k0, k1, g0, g1);
        release_reqs();
        wait_xfers(22, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_reach got=%0d want=22", mon_q.size()); end
        build_pass();
        exp1 = exp_pass;
        exp1[18 + 9] = {1'b1, 8'h5A};   // position 25 not yet offered
        write_cycle(1'b1, 5'd25, 8'h5A, 1'b0, 5'd0, 8'h00, k0, k1, g0, g1);
        checks++; if (k0 !== 1'b1) begin failures++; $display("FAIL mid_ackZ got=%b want=1", k0); end
        write_cycle(1'b1, 5'd3, 8'h59, 1'b0, 5'd0, 8'h00, k0, k1, g0, g1);
        checks++; if (k0 !== 1'b1) begin failures++; $display("FAIL mid_ackY got=%b want=1", k0); end
        release_reqs();
        collect(500, ok);
        build_pass();
        checks++; if (!ok || got.size() != 68) begin failures++; $display("FAIL mid_len got=%0d want=68", got.size()); end
        for (int i = 0; i < got.size() && i < 68; i++) begin
            checks++; if (got[i] !== ((i < 34) ? exp1[i] : exp_pass[i - 34])) begin
                failures++; $display("FAIL mid_pass[%0d] got=%h want=%h", i, got[i],
                                     (i < 34) ? exp1[i] : exp_pass[i - 34]); end
        end
    endtask

    task automatic test_random();
        logic k0, k1;
        bit g0, g1, ok, w0, w1;
        logic [4:0] a0, a1;
        logic [7:0] c0, c1;
        ready_rand = 1'b1;
        for (int it = 0; it < 8; it++) begin
            w0 = $urandom_range(0, 1);
            w1 = w0 ? bit'($urandom_range(0, 1)) : 1'b1;
            a0 = 5'($urandom_range(0, 31)); a1 = 5'($urandom_range(0, 31));
            c0 = 8'($urandom_range(33, 126)); c1 = 8'($urandom_range(33, 126));
            write_cycle(w0, a0, c0, w1, a1, c1, k0, k1, g0, g1);
            checks++; if (k0 !== g0 || k1 !== g1) begin
                failures++; $display("FAIL rnd%0d_ack got=%b%b want=%b%b", it, k0, k1, g0, g1); end
            if (w0 && w1) begin
                write_cycle(!g0, a0, c0, !g1, a1, c1, k0, k1, g0, g1);
                checks++; if (k0 !== g0 || k1 !== g1) begin
                    failures++; $display("FAIL rnd%0d_hold got=%b%b want=%b%b", it, k0, k1, g0, g1); end
            end
            release_reqs();
            collect(1500, ok);
            build_pass();
            checks++; if (!ok || got.size() == 0 || got.size() % 34 != 0) begin
                failures++; $display("FAIL rnd%0d_len got=%0d want=multiple of 34", it, got.size()); end
            for (int i = 0; i < got.size(); i++) begin
                checks++; if (got[i] !== exp_pass[i % 34]) begin
                    failures++; $display("FAIL rnd%0d_pass[%0d] got=%h want=%h", it, i, got[i], exp_pass[i % 34]); end
            end
        end
        ready_rand = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
    endtask

    task automatic init_pass_check(input string nm);
        bit ok;
        collect(400, ok);
        build_pass();
        checks++; if (!ok || got.size() != 38) begin failures++; $display("FAIL %s_len got=%0d want=38", nm, got.size()); end
        for (int i = 0; i < got.size() && i < 38; i++) begin
            checks++; if (got[i] !== ((i < 4) ? xfer_t'({1'b0, cmds[i]}) : exp_pass[i - 4])) begin
                failures++; $display("FAIL %s[%0d] got=%h want=%h", nm, i, got[i],
                                     (i < 4) ? xfer_t'({1'b0, cmds[i]}) : exp_pass[i - 4]); end
        end
    endtask

    task automatic test_reset_mid();
        logic k0, k1;
        bit g0, g1, ok;
        write_cycle(1'b1, 5'd7, 8'h51, 1'b0, 5'd0, 8'h00, k0, k1, g0, g1);
        release_reqs();
        wait_xfers(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_reach got=%0d want=10", mon_q.size()); end
        rst = 1'b0;
        req0_wr = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_rs !== 1'b0 || out_byte !== 8'h00) begin
            failures++; $display("FAIL rstmid_out got=%b/%b/%h want=0/0/00", out_valid, out_rs, out_byte); end
        checks++; if (busy !== 1'b1 || init_done !== 1'b0 || req0_ack !== 1'b0) begin
            failures++; $display("FAIL rstmid_status got=%b/%b/%b want=1/0/0", busy, init_done, req0_ack); end
        req0_wr = 1'b0;
        model_reset();
        mon_q.delete(); mon_cyc.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_byte !== 8'h28) begin
            failures++; $display("FAIL rstmid_first got=%b/%h want=1/28", out_valid, out_byte); end
        init_pass_check("rstmid");
    endtask

    task automatic test_init_write();
        logic k0, k1;
        bit g0, g1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        mon_q.delete(); mon_cyc.delete();
        rst = 1'b1;
        write_cycle(1'b1, 5'd16, 8'h48, 1'b0, 5'd0, 8'h00, k0, k1, g0, g1);
        checks++; if (k0 !== 1'b1) begin failures++; $display("FAIL initwr_ack got=%b want=1", k0); end
        release_reqs();
        init_pass_check("initwr");
        checks++; if (got.size() < 23 || got[22] !== {1'b1, 8'h48}) begin
            failures++; $display("FAIL initwr_char got=%0d bytes want=0x48 after C0", got.size()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_powerup();
        test_arbitration();
        test_backpressure();
        test_mid_write();
        test_random();
        test_reset_mid();
        test_init_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
